snitch_shared_muldiv_arbiter: RTL and testbench

Shares one cluster-level integer multiply/divide unit among NrCores Snitch cores. The unit sits behind the accelerator interface at acc_addr_e SHARED_MULDIV. Each core has its own valid/ready request and response channel into this block. The block arbitrates requests round-robin, keeps each granted request stable until the unit accepts it, and routes the in-order responses back to the issuing core through an outstanding-index FIFO.

---
 rtl/snitch_shared_muldiv_arbiter_pkg.sv | 39 +++
 rtl/snitch_shared_muldiv_arbiter_rr_picker.sv | 43 ++++
 rtl/snitch_shared_muldiv_arbiter.sv | 162 ++++++++++++++++
 tb/tb_snitch_shared_muldiv_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/snitch_shared_muldiv_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// snitch_shared_muldiv_arbiter_pkg
// Shared types for the cluster-level integer multiply/divide unit and its
// per-core request arbiter.
//   MuldivReqWidth / MuldivRspWidth : payload widths on the accelerator port
//   muldiv_op_e                     : operation selector
//   muldiv_req_t / muldiv_rsp_t     : packed request / response payloads
//   arb_state_e                     : arbiter FSM state
// -----------------------------------------------------------------------------
package snitch_shared_muldiv_arbiter_pkg;

  localparam int unsigned MuldivReqWidth = 104;
  localparam int unsigned MuldivRspWidth = 37;

  typedef enum logic [2:0] {
    MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
  } muldiv_op_e;

  // Raw instruction word is forwarded alongside the decoded op so the unit
  // can recover sub-fields without a second decode.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    muldiv_op_e  op;
    logic [4:0]  rd_id;
  } muldiv_req_t;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rd_id;
  } muldiv_rsp_t;

  typedef enum logic {
    IDLE,
    HOLD
  } arb_state_e;

endpackage

// File: rtl/snitch_shared_muldiv_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// snitch_shared_muldiv_arbiter_rr_picker
// Combinational round-robin picker: finds the first set bit of `valid`
// scanning upward from ptr+1 with wrap, so the last winner has lowest
// priority.
//   valid : request vector
//   ptr   : index of the previous winner
//   gnt   : one-hot grant
//   idx   : binary index of the grant
//   found : any request present
// -----------------------------------------------------------------------------
module snitch_shared_muldiv_arbiter_rr_picker #(
  parameter  int unsigned NrCores = 8,
  localparam int unsigned IdxW    = $clog2(NrCores)
) (
  input  logic [NrCores-1:0] valid,
  input  logic [IdxW-1:0]    ptr,
  output logic [NrCores-1:0] gnt,
  output logic [IdxW-1:0]    idx,
  output logic               found
);

  logic [IdxW-1:0] cand;

  always_comb begin
    // NOTE: every output gets a default before the loop, so no path leaves
    // a value unassigned and no latch is inferred.
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 1; k <= NrCores; k++) begin
      // Modulo keeps the scan correct for non-power-of-2 core counts.
      cand = IdxW'((32'(ptr) + k) % NrCores);
      if (!found && valid[cand]) begin
        found     = 1'b1;
        idx       = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/snitch_shared_muldiv_arbiter.sv
// -----------------------------------------------------------------------------
// snitch_shared_muldiv_arbiter
// Shares one multiply/divide unit among NrCores cores. Requests are
// arbitrated round-robin; a granted request is held until the unit accepts
// it. Issued core indices go into an in-order FIFO so responses return to
// their issuer.
//
// Optional build macro: SNITCH_MULDIV_ARB_STALL_EN
//   defined   -> core_stall_o[i] pulses whenever core i is valid but not
//                accepted (feeds performance counters)
//   undefined -> core_stall_o tied to 0
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   core_q*_i/o         per-core request channel (payload slice i = core i)
//   core_p*_i/o         per-core response channel, payload broadcast
//   mul_q*_i/o          request channel to the muldiv unit
//   mul_p*_i/o          in-order response channel from the muldiv unit
//   core_stall_o        per-core contention strobe
// -----------------------------------------------------------------------------
module snitch_shared_muldiv_arbiter
  import snitch_shared_muldiv_arbiter_pkg::*;
#(
  parameter int unsigned NrCores        = 8,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned ReqWidth       = MuldivReqWidth,
  parameter int unsigned RspWidth       = MuldivRspWidth
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NrCores-1:0]          core_qvalid_i,
  output logic [NrCores-1:0]          core_qready_o,
  input  logic [NrCores*ReqWidth-1:0] core_qdata_i,
  output logic [NrCores-1:0]          core_pvalid_o,
  input  logic [NrCores-1:0]          core_pready_i,
  output logic [RspWidth-1:0]         core_pdata_o,
  output logic                        mul_qvalid_o,
  input  logic                        mul_qready_i,
  output logic [ReqWidth-1:0]         mul_qdata_o,
  input  logic                        mul_pvalid_i,
  output logic                        mul_pready_o,
  input  logic [RspWidth-1:0]         mul_pdata_i,
  output logic [NrCores-1:0]          core_stall_o
);

  localparam int unsigned IdxW = $clog2(NrCores);
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  typedef logic [IdxW-1:0] idx_t;
  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;

  arb_state_e state_q;
  idx_t       grant_q;
  idx_t       rr_ptr_q;
  idx_t       fifo_q [MaxOutstanding];
  ptr_t       wr_ptr_q, rd_ptr_q;
  cnt_t       count_q;

  logic [NrCores-1:0] pick_gnt, sel_gnt;
  idx_t               pick_idx, sel_idx, head;
  logic               pick_found, full, empty, req_active, q_hs, p_hs;

  snitch_shared_muldiv_arbiter_rr_picker #(
    .NrCores (NrCores)
  ) i_rr_picker (
    .valid (core_qvalid_i),
    .ptr   (rr_ptr_q),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .found (pick_found)
  );

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (count_q == cnt_t'(MaxOutstanding));
  assign empty = (count_q == '0);

  // Full only blocks fresh grants; HOLD was entered with a free slot. Full
  // is the registered count, so a same-cycle pop does not open a slot.
  always_comb begin
    sel_idx    = pick_idx;
    sel_gnt    = pick_gnt;
    req_active = !full && pick_found;
    if (state_q == HOLD) begin
      sel_idx    = grant_q;
      sel_gnt    = NrCores'(1) << grant_q;
      req_active = 1'b1;
    end
    if (rst_i) req_active = 1'b0;
  end

  assign mul_qvalid_o  = req_active;
  assign mul_qdata_o   = req_active ? core_qdata_i[32'(sel_idx)*ReqWidth +: ReqWidth] : '0;
  assign core_qready_o = (req_active && mul_qready_i) ? sel_gnt : '0;
  assign q_hs          = req_active && mul_qready_i;

  // Response routing follows the oldest outstanding index.
  assign head = fifo_q[rd_ptr_q];

  always_comb begin
    core_pvalid_o = '0;
    mul_pready_o  = 1'b0;
    if (!empty && !rst_i) begin
      core_pvalid_o[head] = mul_pvalid_i;
      mul_pready_o        = core_pready_i[head];
    end
  end

  assign p_hs         = mul_pvalid_i && mul_pready_o;
  assign core_pdata_o = mul_pdata_i;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= idx_t'(NrCores - 1);
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (q_hs) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
        rr_ptr_q <= sel_idx;
        state_q  <= IDLE;
      end else if (state_q == IDLE && req_active) begin
        grant_q <= pick_idx;
        state_q <= HOLD;
      end
      if (p_hs) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (q_hs && !p_hs)      count_q <= count_q + 1'b1;
      else if (!q_hs && p_hs) count_q <= count_q - 1'b1;
    end
  end

  // NOTE: FIFO storage is not reset; entries are only read below count_q,
  // which is reset, so clearing the array would only add reset fan-out.
  always_ff @(posedge clk_i) begin
    if (q_hs) fifo_q[wr_ptr_q] <= sel_idx;
  end

`ifdef SNITCH_MULDIV_ARB_STALL_EN
  assign core_stall_o = rst_i ? '0 : (core_qvalid_i & ~core_qready_o);
`else
  assign core_stall_o = '0;
`endif

`ifndef SYNTHESIS
  // A core must not drop a request that is waiting for the unit.
  hold_valid_kept : assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q == HOLD) |-> core_qvalid_i[grant_q]);
  // The unit may only respond to something that was issued.
  no_rsp_when_empty : assert property (@(posedge clk_i) disable iff (rst_i)
    mul_pvalid_i |-> !empty);
`endif

endmodule

// File: tb/tb_snitch_shared_muldiv_arbiter.sv
module tb_snitch_shared_muldiv_arbiter;
  import snitch_shared_muldiv_arbiter_pkg::*;

  localparam int NrCores  = 4;
  localparam int MaxOut   = 3;
  localparam int ReqWidth = MuldivReqWidth;
  localparam int RspWidth = MuldivRspWidth;

  logic                        clk = 1'b0;
  logic                        rst;
  logic [NrCores-1:0]          core_qvalid, core_qready, core_pvalid, core_pready, core_stall;
  logic [NrCores*ReqWidth-1:0] core_qdata;
  logic [RspWidth-1:0]         core_pdata, mul_pdata;
  logic                        mul_qvalid, mul_qready, mul_pvalid, mul_pready;
  logic [ReqWidth-1:0]         mul_qdata;
  logic [ReqWidth-1:0]         payload [NrCores];

  typedef struct { int core; logic [ReqWidth-1:0] data; } q_exp_t;
  typedef struct { int core; logic [RspWidth-1:0] data; } p_exp_t;
  q_exp_t exp_q [$];
  p_exp_t exp_p [$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign core_qdata = {payload[3], payload[2], payload[1], payload[0]};

  snitch_shared_muldiv_arbiter #(
    .NrCores(NrCores), .MaxOutstanding(MaxOut), .ReqWidth(ReqWidth), .RspWidth(RspWidth)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .core_qvalid_i(core_qvalid), .core_qready_o(core_qready), .core_qdata_i(core_qdata),
    .core_pvalid_o(core_pvalid), .core_pready_i(core_pready), .core_pdata_o(core_pdata),
    .mul_qvalid_o(mul_qvalid), .mul_qready_i(mul_qready), .mul_qdata_o(mul_qdata),
    .mul_pvalid_i(mul_pvalid), .mul_pready_o(mul_pready), .mul_pdata_i(mul_pdata),
    .core_stall_o(core_stall)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [NrCores-1:0] exp_stall(input logic [NrCores-1:0] v);
`ifdef SNITCH_MULDIV_ARB_STALL_EN
    return v;
`else
    return '0;
`endif
  endfunction

  function automatic logic [RspWidth-1:0] rsp(input int k);
    muldiv_rsp_t r;
    r.result = 32'hC0DE_0000 + 32'(k);
    r.rd_id  = 5'(k);
    return r;
  endfunction

  function automatic logic [NrCores-1:0] onehot(input int c);
    logic [NrCores-1:0] one;
    one = 1;
    return one << c;
  endfunction

  task automatic push_q(input int c);
    q_exp_t e;
    e.core = c; e.data = payload[c];
    exp_q.push_back(e);
  endtask

  task automatic push_p(input int c, input logic [RspWidth-1:0] d);
    p_exp_t e;
    e.core = c; e.data = d;
    exp_p.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    core_qvalid = '0; mul_qready = 1'b0; mul_pvalid = 1'b0; mul_pdata = '0; core_pready = '1;
  endtask

  // Monitor: pops the scoreboards on every DUT handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (mul_qvalid && mul_qready) begin
        if (exp_q.size() == 0) check("q_unexpected", 1, 0);
        else begin
          q_exp_t e;
          e = exp_q.pop_front();
          check("q_data", mul_qdata, e.data);
          check("q_ready", core_qready, onehot(e.core));
        end
      end
      if (mul_pvalid && mul_pready) begin
        if (exp_p.size() == 0) check("p_unexpected", 1, 0);
        else begin
          p_exp_t e;
          e = exp_p.pop_front();
          check("p_valid", core_pvalid, onehot(e.core));
          check("p_data", core_pdata, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int c = 0; c < NrCores; c++) begin
      muldiv_req_t r;
      r.instr     = 32'h0200_0033;
      r.operand_a = 32'h1000_0000 + 32'(c);
      r.operand_b = 32'hABCD_0000 + 32'(c);
      r.op        = muldiv_op_e'(3'(c));
      r.rd_id     = 5'(c + 1);
      payload[c]  = r;
    end
    rst = 1'b1;
    idle_inputs();
    cyc(); cyc();

    // Reset state
    @(negedge clk);
    check("rst_qvalid", mul_qvalid, 0);
    check("rst_qdata", mul_qdata, 0);
    check("rst_qready", core_qready, 0);
    check("rst_pvalid", core_pvalid, 0);
    check("rst_pready", mul_pready, 0);
    check("rst_stall", core_stall, 0);
    cyc();
    rst = 1'b0;

    // Round robin, back-to-back with same-cycle push/pop across FIFO wrap
    for (int c = 0; c < 11; c++) begin
      core_qvalid = (c < 10) ? 4'hF : 4'h0;
      mul_qready  = 1'b1;
      mul_pvalid  = (c >= 1);
      mul_pdata   = rsp(c);
      if (c < 10) push_q(c % 4);
      if (c >= 1) push_p((c - 1) % 4, rsp(c));
      cyc();
    end
    idle_inputs();

    // Hold: core 2 granted, unit stalls 3 cycles while core 1 joins
    for (int h = 0; h < 3; h++) begin
      core_qvalid = (h == 0) ? 4'b0100 : 4'b0110;
      mul_qready  = 1'b0;
      @(negedge clk);
      check("hold_qvalid", mul_qvalid, 1);
      check("hold_qdata", mul_qdata, payload[2]);
      check("hold_qready", core_qready, 0);
      check("hold_stall", core_stall, exp_stall(core_qvalid));
      cyc();
    end
    core_qvalid = 4'b0110; mul_qready = 1'b1; push_q(2);
    @(negedge clk);
    check("hold_release_stall", core_stall, exp_stall(4'b0010));
    cyc();
    core_qvalid = 4'b0010; push_q(1);   // core 3 idle: wraps to core 1
    cyc();
    idle_inputs();

    // Response backpressure from the head core
    for (int p = 0; p < 2; p++) begin
      mul_pvalid = 1'b1; mul_pdata = rsp(20); core_pready = 4'b1011;
      @(negedge clk);
      check("bp_pvalid", core_pvalid, 4'b0100);
      check("bp_pready", mul_pready, 0);
      cyc();
    end
    core_pready = 4'hF; push_p(2, rsp(20));
    cyc();
    mul_pdata = rsp(21); push_p(1, rsp(21));
    cyc();
    idle_inputs();

    // FIFO full: three grants to core 0, then blocked even through a pop
    core_qvalid = 4'b0001; mul_qready = 1'b1;
    for (int g = 0; g < 3; g++) begin
      push_q(0);
      cyc();
    end
    @(negedge clk);
    check("full_qvalid", mul_qvalid, 0);
    check("full_qready", core_qready, 0);
    check("full_stall", core_stall, exp_stall(4'b0001));
    cyc();
    mul_pvalid = 1'b1; mul_pdata = rsp(30); push_p(0, rsp(30));
    @(negedge clk);
    check("full_pop_qvalid", mul_qvalid, 0);
    cyc();
    mul_pvalid = 1'b0; push_q(0);
    @(negedge clk);
    check("after_pop_qvalid", mul_qvalid, 1);
    cyc();
    core_qvalid = '0;
    for (int k = 31; k < 34; k++) begin
      mul_pvalid = 1'b1; mul_pdata = rsp(k); push_p(0, rsp(k));
      cyc();
    end
    idle_inputs();

    // Reset with two in flight and core 1 in HOLD
    core_qvalid = 4'b1100; mul_qready = 1'b1; push_q(2);
    cyc();
    core_qvalid = 4'b1000; push_q(3);
    cyc();
    core_qvalid = 4'b0010; mul_qready = 1'b0;
    @(negedge clk);
    check("pre_rst_qdata", mul_qdata, payload[1]);
    cyc();
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_qvalid", mul_qvalid, 0);
    check("mid_rst_qready", core_qready, 0);
    check("mid_rst_pready", mul_pready, 0);
    check("mid_rst_stall", core_stall, 0);
    cyc();
    rst = 1'b0; core_qvalid = '0;
    @(negedge clk);
    check("post_rst_qvalid", mul_qvalid, 0);
    check("post_rst_empty", mul_pready, 0);
    check("post_rst_pvalid", core_pvalid, 0);
    cyc();
    core_qvalid = 4'hF; mul_qready = 1'b1; push_q(0);
    cyc();
    core_qvalid = 4'b1110; push_q(1);
    cyc();
    idle_inputs();
    for (int k = 0; k < 2; k++) begin
      mul_pvalid = 1'b1; mul_pdata = rsp(40 + k); push_p(k, rsp(40 + k));
      cyc();
    end
    idle_inputs();
    cyc();

    check("q_scoreboard_drained", 32'(exp_q.size()), 0);
    check("p_scoreboard_drained", 32'(exp_p.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
